ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED "set LEDs" or 0xFF "reset", from the FPGA to the keyboard. It runs the inhibit/request-to-send sequence, shifts data on device-generated clock falling edges, and checks the device ACK. It sits beside the keyboard receiver on the same open-drain ps2_clk/ps2_data pins. Its `busy` output tells the receiver to discard frames while a transmit is in progress.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_sync.sv | 42 ++++
 rtl/ps2_host_tx.sv | 157 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and
// the device acknowledge code used by the keyboard receiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_SHIFT,
      ST_ACK,
      ST_WAIT_IDLE
   } ps2_tx_state_t;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ECHO     = 8'hEE;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] ACK_CODE     = 8'hFA;

   // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Three-flop synchronizers for the raw ps2_clk/ps2_data pins plus
// falling-edge detection on the clock line. Shared with the receiver.
module ps2_line_sync
   import ps2_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic clk_sync,
   output logic data_sync,
   output logic clk_fall
);

   logic clk_r0, clk_r1, clk_r2;
   logic data_r0, data_r1, data_r2;

   // Shift both pins through their chains; reset to the idle (high) bus level
   // so leaving reset never looks like a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_r0  <= 1'b1;
         clk_r1  <= 1'b1;
         clk_r2  <= 1'b1;
         data_r0 <= 1'b1;
         data_r1 <= 1'b1;
         data_r2 <= 1'b1;
      end else begin
         clk_r0  <= ps2_clk_in;
         clk_r1  <= clk_r0;
         clk_r2  <= clk_r1;
         data_r0 <= ps2_data_in;
         data_r1 <= data_r0;
         data_r2 <= data_r1;
      end
   end

   assign clk_fall  = clk_r2 & ~clk_r1;
   assign clk_sync  = clk_r2;
   assign data_sync = data_r2;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send,
// shift 8 data + parity + stop on device clock falls, then check the ACK.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 10000,
   parameter int unsigned START_CYCLES   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int unsigned MAX_A   = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int          CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(START_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   ps2_tx_state_t    state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       bit_cnt;
   logic [7:0]       shift_r;
   logic             parity_r;

   logic clk_sync, data_sync, clk_fall;

   ps2_line_sync u_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .clk_sync    (clk_sync),
      .data_sync   (data_sync),
      .clk_fall    (clk_fall)
   );

   // Transmit sequencer; all outputs are registered. The shared counter times
   // inhibit and start phases, then becomes the frame timeout from clock release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         shift_r     <= '0;
         parity_r    <= 1'b0;
         tx_ready    <= 1'b1;
         busy        <= 1'b0;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         tx_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               // tx_ready is held low for the pulse cycle, so requests then are dropped
               if (tx_ready && tx_valid) begin
                  shift_r    <= tx_data;
                  parity_r   <= odd_parity(tx_data);
                  tx_ready   <= 1'b0;
                  busy       <= 1'b1;
                  ps2_clk_oe <= 1'b1;
                  cnt        <= '0;
                  state      <= ST_INHIBIT;
               end else begin
                  tx_ready <= 1'b1;
               end
            end

            ST_INHIBIT: begin
               if (cnt == INH_LAST) begin
                  cnt         <= '0;
                  ps2_data_oe <= 1'b1;
                  state       <= ST_REQ;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_REQ: begin
               if (cnt == ST_LAST) begin
                  cnt        <= '0;
                  bit_cnt    <= '0;
                  ps2_clk_oe <= 1'b0;
                  state      <= ST_SHIFT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
               if (cnt == TO_LAST) begin
                  // timeout takes priority over any line event this cycle
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  tx_err      <= 1'b1;
                  busy        <= 1'b0;
                  state       <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (state == ST_SHIFT) begin
                     if (clk_fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd8) begin
                           ps2_data_oe <= ~shift_r[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                           ps2_data_oe <= ~parity_r;
                        end else begin
                           ps2_data_oe <= 1'b0;
                           state       <= ST_ACK;
                        end
                     end
                  end else if (state == ST_ACK) begin
                     if (clk_fall) begin
                        if (!data_sync) begin
                           state <= ST_WAIT_IDLE;
                        end else begin
                           tx_err <= 1'b1;
                           busy   <= 1'b0;
                           state  <= ST_IDLE;
                        end
                     end
                  end else begin
                     if (clk_sync && data_sync) begin
                        tx_done <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                     end
                  end
               end
            end

            default: begin
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               busy        <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model clocks frames out of the DUT over
// wired-AND pins, and a per-cycle checker compares outputs with a timeline model.
module tb_ps2_host_tx;

   localparam int INH = 20;
   localparam int STC = 4;
   localparam int TO  = 600;
   localparam int H   = 12;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe;
   logic       ps2_clk_in, ps2_data_in;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;

   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .START_CYCLES   (STC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .tx_done     (tx_done),
      .tx_err      (tx_err),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // timeline model
   logic m_busy = 1'b0;
   logic m_ready = 1'b1;
   logic m_exp_err = 1'b0;
   logic m_silent = 1'b0;
   int   m_since = 0;
   int   n_done = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // expected frame as the device sees it: data LSB first, odd parity, stop=1
   function automatic logic [9:0] exp_frame(input logic [7:0] d);
      logic [9:0] f;
      for (int i = 0; i < 8; i++) f[i] = d[i];
      f[8] = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
      f[9] = 1'b1;
      return f;
   endfunction

   // per-cycle compare of all DUT outputs against the timeline model
   always @(negedge clk) begin
      if (!rst_n) begin
         m_busy  = 1'b0;
         m_ready = 1'b1;
         m_since = 0;
      end else begin
         check("pulse_exclusive", {31'd0, tx_done & tx_err}, 32'd0);
         if (tx_done || tx_err) begin
            check("pulse_in_transfer", {31'd0, m_busy}, 32'd1);
            check("pulse_kind_err", {31'd0, tx_err}, {31'd0, m_exp_err});
            check("busy_at_pulse", {31'd0, busy}, 32'd0);
            check("ready_at_pulse", {31'd0, tx_ready}, 32'd0);
            check("oe_at_pulse", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            if (m_silent) check("timeout_cycle", m_since, INH + STC + 1 + TO);
            if (tx_done) n_done++;
            if (tx_err) n_err++;
            m_busy  = 1'b0;
            m_ready = 1'b1;
         end else begin
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("tx_ready", {31'd0, tx_ready}, {31'd0, m_ready});
            if (!m_busy) begin
               check("oe_idle", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            end else if (m_since <= INH) begin
               check("oe_inhibit", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd2);
            end else if (m_since <= INH + STC) begin
               check("oe_request", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd3);
            end else begin
               check("clk_released", {31'd0, ps2_clk_oe}, 32'd0);
               if (m_silent) begin
                  check("start_bit_held", {31'd0, ps2_data_oe}, 32'd1);
                  check("timeout_missing", {31'd0, m_since != INH + STC + 1 + TO}, 32'd1);
               end
            end
            if (m_ready && tx_valid) begin
               m_ready = 1'b0;
               m_busy  = 1'b1;
               m_since = 1;
            end else if (m_busy) begin
               m_since++;
            end
         end
      end
   end

   task automatic send(input logic [7:0] d);
      int w;
      w = 0;
      while (!m_ready && w < 1000) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1;
      tx_valid = 1'b1;
      tx_data  = d;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
   endtask

   // device model; mode 0 = ACK, 1 = NACK, 2 = never clocks, 3 = reset at bit 4
   task automatic dev_frame(input int mode, output logic [9:0] bits);
      int w;
      bits = '0;
      w = 0;
      while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("rts_seen", {31'd0, w < 200}, 32'd1);
      if (mode == 2) begin
         w = 0;
         while (m_busy && w < TO + 100) begin
            @(negedge clk);
            w++;
         end
         check("timeout_end", {31'd0, m_busy}, 32'd0);
         return;
      end
      repeat (H) @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         dev_clk = 1'b0;
         repeat (H) @(negedge clk);
         if (mode == 3 && i == 4) begin
            rst_n = 1'b0;
            #1;
            check("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            check("reset_ready", {31'd0, tx_ready}, 32'd1);
            check("reset_busy", {31'd0, busy}, 32'd0);
            dev_clk = 1'b1;
            return;
         end
         dev_clk = 1'b1;
         if (i < 10) bits[i] = ps2_data_in;
         if (i == 9) dev_data = (mode == 1) ? 1'b1 : 1'b0;
         repeat (H) @(negedge clk);
      end
      dev_data = 1'b1;
      w = 0;
      while (m_busy && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("frame_end", {31'd0, m_busy}, 32'd0);
   endtask

   task automatic run(input logic [7:0] d, input int mode, output logic [9:0] bits);
      int d0, e0;
      d0 = n_done;
      e0 = n_err;
      m_exp_err = (mode == 1 || mode == 2);
      m_silent  = (mode == 2);
      send(d);
      dev_frame(mode, bits);
      if (mode == 0) begin
         check("frame_bits", {22'd0, bits}, {22'd0, exp_frame(d)});
         check("done_once", n_done - d0, 1);
         check("no_err", n_err - e0, 0);
      end else if (mode != 3) begin
         check("err_once", n_err - e0, 1);
         check("no_done", n_done - d0, 0);
      end
      $display("xfer data=%02h mode=%0d bits=%03h done=%0d err=%0d", d, mode, bits, n_done - d0, n_err - e0);
      m_silent = 1'b0;
   endtask

   initial begin
      logic [9:0] bits;
      logic [7:0] rd;
      int         rm;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_pulses", {30'd0, tx_done, tx_err}, 32'd0);
      check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      run(8'hED, 0, bits);
      check("ed_literal", {22'd0, bits}, 32'h3ED);
      run(8'h07, 0, bits);
      check("07_parity", {31'd0, bits[8]}, 32'd0);
      run(8'h00, 0, bits);
      check("00_parity", {31'd0, bits[8]}, 32'd1);
      run(8'hF4, 1, bits);
      run(8'hEE, 2, bits);

      run(8'hAB, 3, bits);
      repeat (2) @(posedge clk);
      #1;
      dev_data = 1'b1;
      rst_n = 1'b1;
      check("post_reset_ready", {31'd0, tx_ready}, 32'd1);
      run(8'hFF, 0, bits);
      check("ff_parity", {31'd0, bits[8]}, 32'd1);

      // a request while busy must neither disturb nor follow the current frame
      m_exp_err = 1'b0;
      send(8'h3C);
      fork
         dev_frame(0, bits);
         begin
            repeat (60) @(posedge clk);
            #1;
            tx_valid = 1'b1;
            tx_data  = 8'h55;
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
         end
      join
      check("busy_ignore_bits", {22'd0, bits}, {22'd0, exp_frame(8'h3C)});
      $display("xfer data=3c with 0x55 while busy bits=%03h", bits);
      repeat (100) @(posedge clk);

      for (int k = 0; k < 6; k++) begin
         rd = 8'($urandom);
         rm = $urandom_range(0, 1);
         run(rd, rm, bits);
      end

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
